// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin arbiter that shares one UART
// byte serializer between NUM_REQ sources. A granted source keeps the
// transmitter until its req_last byte is accepted, so messages never interleave.
// Optional stall watchdog: define UART_ARB_TIMEOUT_EN to build the timeout counter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 480000
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]                       req_data,
  input  logic [NUM_REQ-1:0]                              req_last,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic                                            tx_valid,
  output logic [DATA_W-1:0]                               tx_data,
  input  logic                                            tx_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                            busy,
  output logic                                            timeout
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state;
  logic [GW-1:0]       ptr;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       cand;
  logic                pick_found;
  logic                xfer;
  logic                last_g;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  // Unpack the flat source bus into one byte per source
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid source searching upward from ptr+1, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(ptr) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Zero-latency pass-through from the owner to the serializer while streaming
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state == STREAM) begin
      tx_valid            = req_valid[grant_id];
      tx_data             = data_arr[grant_id];
      req_ready[grant_id] = tx_ready;
    end
  end

  assign xfer   = tx_valid && tx_ready;
  assign last_g = req_last[grant_id];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  // Arbitration FSM with stall watchdog; a stalled owner is released and loses priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      ptr       <= GW'(NUM_REQ - 1);
      busy      <= 1'b0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            state     <= STREAM;
            busy      <= 1'b1;
            stall_cnt <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (last_g) begin
              ptr   <= grant_id;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout   <= 1'b1;
            ptr       <= grant_id;
            state     <= IDLE;
            busy      <= 1'b0;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  // Arbitration FSM; the owner keeps the grant until its last byte is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      ptr      <= GW'(NUM_REQ - 1);
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= STREAM;
            busy     <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer && last_g) begin
            ptr   <= grant_id;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule
